// File: rtl/seg_pipe_carry_adder.sv
// rtl/seg_pipe_carry_adder.sv - segmented pipelined carry adder, one register stage per carry segment
module seg_pipe_carry_adder #(
  parameter int WIDTH = 40,
  parameter int SEG   = 8,
  parameter int TRUNC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy
);

  localparam int NSEG = (WIDTH + SEG - 1) / SEG;
  // Operands are zero-padded to whole segments so the last carry cell sees 0 on unused inputs.
  localparam int PW   = NSEG * SEG;
  // Width of the last (possibly narrower) segment; carry out of bit WIDTH-1 sits at this index.
  localparam int LW   = WIDTH - (NSEG - 1) * SEG;
  localparam logic [PW-1:0] ONE   = PW'(1);
  // Bits below TRUNC are approximated as a|b and never produce a carry.
  localparam logic [PW-1:0] TMASK = (ONE << TRUNC) - ONE;

  logic stall;
  logic accept;

  logic          v_q   [NSEG];
  logic [PW-1:0] a_q   [NSEG];
  logic [PW-1:0] b_q   [NSEG];
  logic [PW-1:0] s_q   [NSEG];
  logic          c_q   [NSEG];
  logic          cin_q [NSEG];
  logic          sg_q  [NSEG];
  logic          ext_q;

  logic          src_v  [NSEG];
  logic [PW-1:0] op_a   [NSEG];
  logic [PW-1:0] op_b   [NSEG];
  logic [PW-1:0] op_s   [NSEG];
  logic          op_c   [NSEG];
  logic          op_cin [NSEG];
  logic          op_sg  [NSEG];

  logic [PW-1:0] nx_s [NSEG];
  logic          nx_c [NSEG];
  logic          nx_ext;

  logic unused_last;

  assign stall     = v_q[NSEG-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;
  assign out_valid = v_q[NSEG-1];
  assign out_sum   = {ext_q, s_q[NSEG-1][WIDTH-1:0]};

  // The last stage only feeds out_sum; its delayed operands and carry have no consumer.
  assign unused_last = ^{a_q[NSEG-1], b_q[NSEG-1], s_q[NSEG-1],
                         c_q[NSEG-1], cin_q[NSEG-1], sg_q[NSEG-1]};

  // Select what each stage works on: the input port for stage 0, the previous stage register otherwise.
  always_comb begin
    src_v[0]  = accept;
    op_a[0]   = PW'(in_a);
    op_b[0]   = PW'(in_b);
    op_s[0]   = '0;
    op_c[0]   = 1'b0;
    op_cin[0] = in_cin;
    op_sg[0]  = in_signed;
    for (int k = 1; k < NSEG; k++) begin
      src_v[k]  = v_q[k-1];
      op_a[k]   = a_q[k-1];
      op_b[k]   = b_q[k-1];
      op_s[k]   = s_q[k-1];
      op_c[k]   = c_q[k-1];
      op_cin[k] = cin_q[k-1];
      op_sg[k]  = sg_q[k-1];
    end
  end

  // Per-segment carry cell: exact add above TRUNC with carry-in injected at bit TRUNC, OR below it.
  always_comb begin
    logic [SEG:0]   tot;
    logic [PW-1:0]  cv;
    logic [SEG-1:0] am;
    logic [SEG-1:0] bm;
    logic [SEG-1:0] om;
    logic           last_c;
    tot    = '0;
    cv     = '0;
    am     = '0;
    bm     = '0;
    om     = '0;
    last_c = 1'b0;
    for (int k = 0; k < NSEG; k++) begin
      cv       = op_cin[k] ? (ONE << TRUNC) : '0;
      am       = op_a[k][k*SEG +: SEG] & ~TMASK[k*SEG +: SEG];
      bm       = op_b[k][k*SEG +: SEG] & ~TMASK[k*SEG +: SEG];
      om       = (op_a[k][k*SEG +: SEG] | op_b[k][k*SEG +: SEG]) & TMASK[k*SEG +: SEG];
      tot      = {1'b0, am} + {1'b0, bm} + {1'b0, cv[k*SEG +: SEG]} + {{SEG{1'b0}}, op_c[k]};
      nx_s[k]  = op_s[k];
      nx_s[k][k*SEG +: SEG] = tot[SEG-1:0] | om;
      nx_c[k]  = tot[SEG];
      if (k == NSEG - 1) begin
        last_c = tot[LW];
      end
    end
    // Signed results take the true sign of the WIDTH+1-bit sum; unsigned take the carry-out.
    nx_ext = op_sg[NSEG-1] ? (op_a[NSEG-1][WIDTH-1] ^ op_b[NSEG-1][WIDTH-1] ^ last_c) : last_c;
  end

  // Pipeline registers: all hold on stall; data loads only behind a valid so out_sum keeps its last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        cin_q[k] <= 1'b0;
        sg_q[k]  <= 1'b0;
      end
      ext_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k] <= src_v[k];
        if (src_v[k]) begin
          a_q[k]   <= op_a[k];
          b_q[k]   <= op_b[k];
          s_q[k]   <= nx_s[k];
          c_q[k]   <= nx_c[k];
          cin_q[k] <= op_cin[k];
          sg_q[k]  <= op_sg[k];
        end
      end
      if (src_v[NSEG-1]) begin
        ext_q <= nx_ext;
      end
    end
  end

  // busy reflects any stage holding a live transaction.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < NSEG; k++) begin
      busy = busy | v_q[k];
    end
  end

endmodule

// File: tb/tb_seg_pipe_carry_adder.sv
// tb/tb_seg_pipe_carry_adder.sv - self-checking bench for seg_pipe_carry_adder (exact and TRUNC=8 instances)
module tb_seg_pipe_carry_adder;

  localparam int W = 40;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_cin = 1'b0;
  logic         in_signed = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;

  logic         in_ready0, in_ready8, out_valid0, out_valid8, busy0, busy8;
  logic [W:0]   out_sum0, out_sum8;

  int checks = 0;
  int failures = 0;

  logic [W:0] q0[$];
  logic [W:0] q8[$];
  logic [W:0] log0[$];

  always #5 clk = ~clk;

  seg_pipe_carry_adder #(.WIDTH(W), .SEG(8), .TRUNC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_signed(in_signed),
    .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0), .busy(busy0)
  );

  seg_pipe_carry_adder #(.WIDTH(W), .SEG(8), .TRUNC(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_signed(in_signed),
    .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8), .busy(busy8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain WIDTH+1-bit arithmetic on extended operands; low trunc bits are a|b, cin enters above them.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sg, input int trunc);
    logic [W:0]  ea, eb;
    logic [32:0] ha, hb, hs;
    if (trunc == 0) begin
      ea = sg ? {a[W-1], a} : {1'b0, a};
      eb = sg ? {b[W-1], b} : {1'b0, b};
      return ea + eb + (W+1)'(cin);
    end else begin
      ha = sg ? {a[W-1], a[W-1:8]} : {1'b0, a[W-1:8]};
      hb = sg ? {b[W-1], b[W-1:8]} : {1'b0, b[W-1:8]};
      hs = ha + hb + 33'(cin);
      return {hs, a[7:0] | b[7:0]};
    end
  endfunction

  // Scoreboard: push on accept, pop and compare on every retire, flush on reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q8.delete();
    end else begin
      if (in_valid && in_ready0) begin
        q0.push_back(model(in_a, in_b, in_cin, in_signed, 0));
        q8.push_back(model(in_a, in_b, in_cin, in_signed, 8));
      end
      check("in_ready0 rule", in_ready0, !(out_valid0 && !out_ready));
      check("in_ready8 rule", in_ready8, !(out_valid8 && !out_ready));
      if (out_valid0 && out_ready) begin
        checks++;
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL unexpected0 actual=%0h required=no output", out_sum0);
        end else begin
          if (out_sum0 !== q0[0]) begin
            failures++;
            $display("FAIL sum0 actual=%0h required=%0h", out_sum0, q0[0]);
          end
          void'(q0.pop_front());
          log0.push_back(out_sum0);
        end
      end
      if (out_valid8 && out_ready) begin
        checks++;
        if (q8.size() == 0) begin
          failures++;
          $display("FAIL unexpected8 actual=%0h required=no output", out_sum8);
        end else begin
          if (out_sum8 !== q8[0]) begin
            failures++;
            $display("FAIL sum8 actual=%0h required=%0h", out_sum8, q8[0]);
          end
          void'(q8.pop_front());
        end
      end
    end
  end

  task automatic single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sg, input logic [W:0] e0, input logic [W:0] e8);
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_signed = sg;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, n, 5);
    check({name, " sum0"}, out_sum0, e0);
    check({name, " sum8"}, out_sum8, e8);
    @(posedge clk); #1;
  endtask

  initial begin
    int  i;
    int  sent;
    int  cyc;
    logic acc;
    logic saw;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset out_valid", out_valid0, 1'b0);
    check("reset out_sum", out_sum0, 0);
    check("reset busy", busy0, 1'b0);
    check("reset in_ready", in_ready0, 1'b1);
    check("reset out_sum8", out_sum8, 0);

    check("model ripple", model(40'hFF_FFFF_FFFF, 40'h1, 1'b0, 1'b0, 0), 41'h100_0000_0000);
    check("model signed wrap", model(40'hFF_FFFF_FFFF, 40'h1, 1'b0, 1'b1, 0), 41'h0);
    check("model signed max", model(40'h7F_FFFF_FFFF, 40'h1, 1'b0, 1'b1, 0), 41'h080_0000_0000);
    check("model approx", model(40'h0F, 40'hF1, 1'b1, 1'b0, 8), 41'h1FF);
    check("model approx neg", model(40'hFF_FFFF_FFFF, 40'h1, 1'b0, 1'b1, 8), 41'h1FF_FFFF_FFFF);

    single("ripple", 40'hFF_FFFF_FFFF, 40'h1, 1'b0, 1'b0, 41'h100_0000_0000, 41'h0FF_FFFF_FFFF);
    single("swrap", 40'hFF_FFFF_FFFF, 40'h1, 1'b0, 1'b1, 41'h0, 41'h1FF_FFFF_FFFF);
    single("smax", 40'h7F_FFFF_FFFF, 40'h1, 1'b0, 1'b1, 41'h080_0000_0000, 41'h07F_FFFF_FFFF);
    single("approx", 40'h0F, 40'hF1, 1'b1, 1'b0, 41'h101, 41'h1FF);

    log0.delete();
    i = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 6 && c <= 8);
      in_valid = (i < 8);
      in_a = W'(i); in_b = W'(i); in_cin = 1'b1; in_signed = 1'b0;
      #1;
      if (c < 16) check($sformatf("bp in_ready c%0d", c), in_ready0, !(c >= 6 && c <= 8));
      acc = in_valid && in_ready0;
      @(posedge clk); #1;
      if (acc) i++;
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    check("bp count", log0.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < log0.size()) check($sformatf("bp result %0d", k), log0[k], 2 * k + 1);
    end

    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_a = W'(100 + c); in_b = W'(c); in_cin = 1'b0; in_signed = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("busy before reset", busy0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post reset busy", busy0, 1'b0);
    check("post reset in_ready", in_ready0, 1'b1);
    saw = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid0 || out_valid8) saw = 1'b1;
      @(posedge clk); #1;
    end
    check("no output after reset", saw, 1'b0);

    sent = 0;
    cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      if (!in_valid && $urandom_range(0, 4) != 0) begin
        in_valid = 1'b1;
        in_a = W'({$urandom(), $urandom()});
        in_b = W'({$urandom(), $urandom()});
        in_cin = 1'($urandom_range(0, 1));
        in_signed = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready0;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    check("random sent", sent, 10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((busy0 || busy8) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain busy0", busy0, 1'b0);
    check("drain busy8", busy8, 1'b0);
    check("drain q0", q0.size(), 0);
    check("drain q8", q8.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
